// File: rtl/mem_arbiter.sv
// Memory arbiter: one single-port memory shared by instruction fetch and data access.
// Only one memory transaction is outstanding at a time, and each response is routed
// back to the requester that owns it. Data normally wins arbitration. A streak
// counter makes sure fetch is not starved by a long run of data grants.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_o
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] d_streak_reg, d_streak_next;
  logic          resp_en, arb_en, d_win, if_win;

  // Arbitration, response routing, memory muxing and next-state logic
  always_comb begin
    state_next    = state_reg;
    d_streak_next = d_streak_reg;
    if_gnt_o      = 1'b0;
    if_rvalid_o   = 1'b0;
    if_rdata_o    = '0;
    d_gnt_o       = 1'b0;
    d_rvalid_o    = 1'b0;
    d_rdata_o     = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_be_o      = '0;
    stall_o       = 1'b0;

    // A memory response only counts while we own a transaction; when IDLE it is stale.
    resp_en = !rst && (state_reg != IDLE) && mem_rvalid_i;
    // A new grant can go out when idle, or back-to-back in the response cycle.
    arb_en  = !rst && ((state_reg == IDLE) || mem_rvalid_i);
    d_win   = arb_en && d_req_i && !(if_req_i && (d_streak_reg == STREAK_MAX));
    if_win  = arb_en && !d_win && if_req_i;

    if (resp_en) begin
      if (state_reg == BUSY_IF) begin
        if_rvalid_o = 1'b1;
        if_rdata_o  = mem_rdata_i;
      end else begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = mem_rdata_i;
      end
      state_next = IDLE;
    end

    if (d_win) begin
      d_gnt_o     = 1'b1;
      mem_req_o   = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
      state_next  = BUSY_D;
      // Only a waiting fetch makes a data grant count towards the streak.
      if (if_req_i) begin
        d_streak_next = (d_streak_reg == STREAK_MAX) ? STREAK_MAX : d_streak_reg + SW'(1);
      end else begin
        d_streak_next = '0;
      end
    end else if (if_win) begin
      if_gnt_o      = 1'b1;
      mem_req_o     = 1'b1;
      mem_addr_o    = if_addr_i;
      state_next    = BUSY_IF;
      d_streak_next = '0;
    end

    if (!rst) begin
      stall_o = (if_req_i && !if_gnt_o) || (d_req_i && !d_gnt_o) ||
                ((state_reg != IDLE) && !mem_rvalid_i);
    end
  end

  // State and streak registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      d_streak_reg <= '0;
    end else begin
      state_reg    <= state_next;
      d_streak_reg <= d_streak_next;
    end
  end

endmodule
